pipeline_hazard_ctrl: RTL and testbench

Hazard and stall controller for the five-stage pipeline. It generates the write-enable and flush controls for the PC and the FD/DE/EM/MW pipeline buffers. It detects load-use hazards in decode, redirects from the execute stage, and multi-cycle data-memory accesses in the memory stage. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipeline_hazard_ctrl_if.sv | 67 ++++++
 rtl/pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Bundles the hazard-detection inputs and the pipeline control outputs that
// pass between the datapath and the hazard/stall controller.
//
// Signals:
//   src1Index_D, src2Index_D  decode source register indices
//   src1Used_D, src2Used_D    decode instruction really reads src1 / src2
//   destIndex_E               execute destination index
//   regWrtEn_E                execute instruction writes the register file
//   regFileMux_E              writeback source select (2'd2 = load)
//   noop_E                    execute stage holds a bubble
//   pc_sel_E                  00 seq, 01 cond branch, 10 jump, 11 jump-and-link
//   cond_flag_E               branch condition result
//   memReq_M                  valid load/store in memory stage
//   memReady                  data memory completes the access this cycle
//   pcWrtEn, wrtEn_FD/DE/EM/MW  PC and pipeline buffer write enables
//   flush_FD, flush_DE        buffer latches a noop instead of its inputs
//   stallCount, flushCount    saturating performance counters
//   memError                  sticky memory timeout flag
//
// Modports:
//   master  the pipeline datapath side (drives hazard inputs)
//   slave   the controller side (drives controls and counters)
interface pipeline_hazard_ctrl_if #(
  parameter int REGBITS = 4,
  parameter int CNTBITS = 16
);
  logic [REGBITS-1:0] src1Index_D;
  logic [REGBITS-1:0] src2Index_D;
  logic               src1Used_D;
  logic               src2Used_D;
  logic [REGBITS-1:0] destIndex_E;
  logic               regWrtEn_E;
  logic [1:0]         regFileMux_E;
  logic               noop_E;
  logic [1:0]         pc_sel_E;
  logic               cond_flag_E;
  logic               memReq_M;
  logic               memReady;

  logic               pcWrtEn;
  logic               wrtEn_FD;
  logic               wrtEn_DE;
  logic               wrtEn_EM;
  logic               wrtEn_MW;
  logic               flush_FD;
  logic               flush_DE;
  logic [CNTBITS-1:0] stallCount;
  logic [CNTBITS-1:0] flushCount;
  logic               memError;

  modport master (
    output src1Index_D, src2Index_D, src1Used_D, src2Used_D,
    output destIndex_E, regWrtEn_E, regFileMux_E, noop_E,
    output pc_sel_E, cond_flag_E, memReq_M, memReady,
    input  pcWrtEn, wrtEn_FD, wrtEn_DE, wrtEn_EM, wrtEn_MW,
    input  flush_FD, flush_DE, stallCount, flushCount, memError
  );

  modport slave (
    input  src1Index_D, src2Index_D, src1Used_D, src2Used_D,
    input  destIndex_E, regWrtEn_E, regFileMux_E, noop_E,
    input  pc_sel_E, cond_flag_E, memReq_M, memReady,
    output pcWrtEn, wrtEn_FD, wrtEn_DE, wrtEn_EM, wrtEn_MW,
    output flush_FD, flush_DE, stallCount, flushCount, memError
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and stall controller for the five-stage pipeline. Produces the PC
// and FD/DE/EM/MW buffer write enables and flushes for load-use hazards in
// decode, redirects from execute, and multi-cycle data-memory accesses in
// the memory stage. Keeps saturating stall/flush counters for debug.
//
// Ports:
//   clk    pipeline clock, all state changes on the rising edge
//   reset  asynchronous, active-low; clears state and counters at once
//   bus    pipeline_hazard_ctrl_if.slave: hazard inputs in, controls out
//
// Parameters:
//   REGBITS      register index width
//   CNTBITS      width of each performance counter
//   MEM_TIMEOUT  maximum frozen cycles before a forced release (1..255)
module pipeline_hazard_ctrl #(
  parameter int REGBITS     = 4,
  parameter int CNTBITS     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t state;
  state_t stateNext;

  logic [7:0] waitCnt;
  logic [7:0] waitCntNext;

  logic [REGBITS-1:0] src1Index;
  logic [REGBITS-1:0] src2Index;
  logic [REGBITS-1:0] destIndex;

  logic redirect;
  logic loadUse;
  logic memBusy;
  logic serve;
  logic timeoutHit;

  logic pcWrtEn;
  logic wrtEnFD;
  logic wrtEnDE;
  logic wrtEnEM;
  logic wrtEnMW;
  logic flushFD;
  logic flushDE;

  logic [CNTBITS-1:0] stallCount;
  logic [CNTBITS-1:0] flushCount;
  logic               memError;

  assign src1Index = bus.src1Index_D;
  assign src2Index = bus.src2Index_D;
  assign destIndex = bus.destIndex_E;

  // A bubble in execute masks every execute-stage hazard term.
  assign redirect = !bus.noop_E &&
                    (bus.pc_sel_E == 2'b10 || bus.pc_sel_E == 2'b11 ||
                     (bus.pc_sel_E == 2'b01 && bus.cond_flag_E));

  assign loadUse = !bus.noop_E && bus.regWrtEn_E && (bus.regFileMux_E == 2'd2) &&
                   ((bus.src1Used_D && (src1Index == destIndex)) ||
                    (bus.src2Used_D && (src2Index == destIndex)));

  assign memBusy = bus.memReq_M && !bus.memReady;

  // Next state and Mealy outputs. 'serve' marks cycles where the pipeline
  // may move: normal RUN cycles without a busy memory, and the MEM_WAIT
  // release cycle, where a redirect or load-use held during the freeze is
  // handled straight away.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    serve       = 1'b0;
    timeoutHit  = 1'b0;
    pcWrtEn     = 1'b0;
    wrtEnFD     = 1'b0;
    wrtEnDE     = 1'b0;
    wrtEnEM     = 1'b0;
    wrtEnMW     = 1'b0;
    flushFD     = 1'b0;
    flushDE     = 1'b0;

    if (reset) begin
      unique case (state)
        RUN: begin
          if (memBusy) begin
            stateNext   = MEM_WAIT;
            waitCntNext = 8'd1;
          end else begin
            serve = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!bus.memReady && (waitCnt < WAIT_LIMIT)) begin
            waitCntNext = waitCnt + 8'd1;
          end else begin
            // Release on completion or on timeout; timeout is only
            // flagged when memory never answered.
            serve       = 1'b1;
            timeoutHit  = !bus.memReady;
            stateNext   = RUN;
            waitCntNext = 8'd0;
          end
        end
        default: begin
          stateNext   = RUN;
          waitCntNext = 8'd0;
        end
      endcase

      if (serve) begin
        pcWrtEn = 1'b1;
        wrtEnFD = 1'b1;
        wrtEnDE = 1'b1;
        wrtEnEM = 1'b1;
        wrtEnMW = 1'b1;
        if (redirect) begin
          // Redirect squashes decode, so a concurrent load-use is moot.
          flushFD = 1'b1;
          flushDE = 1'b1;
        end else if (loadUse) begin
          pcWrtEn = 1'b0;
          wrtEnFD = 1'b0;
          flushDE = 1'b1;
        end
      end
    end
  end

  // State register, saturating counters and the sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      waitCnt    <= 8'd0;
      stallCount <= '0;
      flushCount <= '0;
      memError   <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (!pcWrtEn && !(&stallCount)) begin
        stallCount <= stallCount + 1'b1;
      end
      if (flushFD && !(&flushCount)) begin
        flushCount <= flushCount + 1'b1;
      end
      if (timeoutHit) begin
        memError <= 1'b1;
      end
    end
  end

  assign bus.pcWrtEn    = pcWrtEn;
  assign bus.wrtEn_FD   = wrtEnFD;
  assign bus.wrtEn_DE   = wrtEnDE;
  assign bus.wrtEn_EM   = wrtEnEM;
  assign bus.wrtEn_MW   = wrtEnMW;
  assign bus.flush_FD   = flushFD;
  assign bus.flush_DE   = flushDE;
  assign bus.stallCount = stallCount;
  assign bus.flushCount = flushCount;
  assign bus.memError   = memError;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl: a table of single-cycle
// vectors with hand-written expected controls, hand-written multi-cycle
// sequences (load-use, branch, memory wait, priority, timeout, reset in
// wait, counter saturation) and a randomized phase checked against a
// behavioural model of the controller.
module tb_pipeline_hazard_ctrl;

  localparam int REGB   = 4;
  localparam int CNTB   = 4;
  localparam int TOUT   = 15;
  localparam int CNTMAX = (1 << CNTB) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REGBITS(REGB), .CNTBITS(CNTB)) bus ();

  pipeline_hazard_ctrl #(
    .REGBITS(REGB),
    .CNTBITS(CNTB),
    .MEM_TIMEOUT(TOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] s1;
    logic       u1;
    logic [3:0] s2;
    logic       u2;
    logic [3:0] dE;
    logic       rw;
    logic [1:0] mux;
    logic       noop;
    logic [1:0] pcsel;
    logic       cond;
    logic       req;
    logic       rdy;
  } inVec_t;

  // ctrl bit order: {pcWrtEn, wrtEn_FD, wrtEn_DE, wrtEn_EM, wrtEn_MW, flush_FD, flush_DE}
  typedef struct {
    inVec_t     in;
    logic [6:0] ctrl;
  } vector_t;

  localparam logic [6:0] C_RUN    = 7'b1111100;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_REDIR  = 7'b1111111;
  localparam logic [6:0] C_LU     = 7'b0011101;

  int passCount  = 0;
  int totalCount = 0;

  vector_t tbl[$];

  // Behavioural model: how many cycles the current memory access has been
  // frozen so far (0 = not waiting), plus counters and the error flag.
  int         mWaited;
  int         mStall;
  int         mFlush;
  logic       mErr;
  logic [6:0] mCtrl;
  logic       mRedirect;
  logic       mLoadUse;
  logic       mFrozen;

  always_comb begin
    mRedirect = !bus.noop_E && (bus.pc_sel_E == 2'd2 || bus.pc_sel_E == 2'd3 ||
                                (bus.pc_sel_E == 2'd1 && bus.cond_flag_E));
    mLoadUse  = !bus.noop_E && bus.regWrtEn_E && bus.regFileMux_E == 2'd2 &&
                ((bus.src1Used_D && bus.src1Index_D == bus.destIndex_E) ||
                 (bus.src2Used_D && bus.src2Index_D == bus.destIndex_E));
    if (mWaited == 0) mFrozen = bus.memReq_M && !bus.memReady;
    else              mFrozen = !bus.memReady && mWaited < TOUT;
    if (!reset || mFrozen) mCtrl = C_FREEZE;
    else if (mRedirect)    mCtrl = C_REDIR;
    else if (mLoadUse)     mCtrl = C_LU;
    else                   mCtrl = C_RUN;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mWaited <= 0;
      mStall  <= 0;
      mFlush  <= 0;
      mErr    <= 1'b0;
    end else begin
      if (mWaited == 0) mWaited <= (bus.memReq_M && !bus.memReady) ? 1 : 0;
      else if (!bus.memReady && mWaited < TOUT) mWaited <= mWaited + 1;
      else begin
        if (!bus.memReady) mErr <= 1'b1;
        mWaited <= 0;
      end
      if (mCtrl[6] == 1'b0 && mStall < CNTMAX) mStall <= mStall + 1;
      if (mCtrl[1] == 1'b1 && mFlush < CNTMAX) mFlush <= mFlush + 1;
    end
  end

  function automatic inVec_t mk(int s1, int u1, int s2, int u2, int dE, int rw,
                                int mux, int noop, int pcsel, int cond, int req, int rdy);
    inVec_t v;
    v.s1    = 4'(s1);
    v.u1    = 1'(u1);
    v.s2    = 4'(s2);
    v.u2    = 1'(u2);
    v.dE    = 4'(dE);
    v.rw    = 1'(rw);
    v.mux   = 2'(mux);
    v.noop  = 1'(noop);
    v.pcsel = 2'(pcsel);
    v.cond  = 1'(cond);
    v.req   = 1'(req);
    v.rdy   = 1'(rdy);
    return v;
  endfunction

  function automatic logic [6:0] ctrlNow();
    return {bus.pcWrtEn, bus.wrtEn_FD, bus.wrtEn_DE, bus.wrtEn_EM,
            bus.wrtEn_MW, bus.flush_FD, bus.flush_DE};
  endfunction

  task automatic applyStimulus(inVec_t v);
    bus.src1Index_D  = v.s1;
    bus.src1Used_D   = v.u1;
    bus.src2Index_D  = v.s2;
    bus.src2Used_D   = v.u2;
    bus.destIndex_E  = v.dE;
    bus.regWrtEn_E   = v.rw;
    bus.regFileMux_E = v.mux;
    bus.noop_E       = v.noop;
    bus.pc_sel_E     = v.pcsel;
    bus.cond_flag_E  = v.cond;
    bus.memReq_M     = v.req;
    bus.memReady     = v.rdy;
  endtask

  // Compares all outputs against the behavioural model.
  task automatic checkOutput(string name);
    logic [15:0] got;
    logic [15:0] want;
    got  = {ctrlNow(), bus.stallCount, bus.flushCount, bus.memError};
    want = {mCtrl, CNTB'(mStall), CNTB'(mFlush), mErr};
    totalCount++;
    if (got !== want)
      $display("[TB] FAIL %s: got ctrl=%b stall=%0d flush=%0d err=%b, want ctrl=%b stall=%0d flush=%0d err=%b",
               name, got[15:9], got[8:5], got[4:1], got[0],
               want[15:9], want[8:5], want[4:1], want[0]);
    else
      passCount++;
  endtask

  task automatic checkValue(string name, int got, int want);
    totalCount++;
    if (got != want) $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    else passCount++;
  endtask

  task automatic checkCtrl(string name, logic [6:0] want);
    logic [6:0] got;
    got = ctrlNow();
    totalCount++;
    if (got !== want) $display("[TB] FAIL %s: got ctrl=%b, want ctrl=%b", name, got, want);
    else passCount++;
  endtask

  // One cycle: drive at posedge+1, check at posedge+4, then advance.
  task automatic step(inVec_t v, logic [6:0] want, string name);
    applyStimulus(v);
    #3;
    checkCtrl(name, want);
    checkOutput({name, "_model"});
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  inVec_t IDLE, LU, LU_BUB, LU_NOUSE, BRT, BRNT, JALNOOP, MW, MR, MWB, MRB, IDLE_NRDY, rv;

  initial begin
    IDLE      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    LU        = mk(3, 1, 0, 0, 3, 1, 2, 0, 0, 0, 0, 1);
    LU_BUB    = mk(3, 1, 0, 0, 3, 1, 2, 1, 0, 0, 0, 1);
    LU_NOUSE  = mk(3, 0, 0, 0, 3, 1, 2, 0, 0, 0, 0, 1);
    BRT       = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    BRNT      = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    JALNOOP   = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1);
    MW        = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    MR        = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    MWB       = mk(3, 1, 0, 0, 3, 1, 2, 0, 1, 1, 1, 0);
    MRB       = mk(3, 1, 0, 0, 3, 1, 2, 0, 1, 1, 1, 1);
    IDLE_NRDY = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl.push_back('{in: IDLE,                                      ctrl: C_RUN});
    tbl.push_back('{in: LU,                                        ctrl: C_LU});
    tbl.push_back('{in: LU_NOUSE,                                  ctrl: C_RUN});
    tbl.push_back('{in: mk(1, 1, 5, 1, 5, 1, 2, 0, 0, 0, 0, 1),    ctrl: C_LU});
    tbl.push_back('{in: mk(3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1),    ctrl: C_RUN});
    tbl.push_back('{in: mk(3, 1, 0, 0, 3, 0, 2, 0, 0, 0, 0, 1),    ctrl: C_RUN});
    tbl.push_back('{in: LU_BUB,                                    ctrl: C_RUN});
    tbl.push_back('{in: BRT,                                       ctrl: C_REDIR});
    tbl.push_back('{in: BRNT,                                      ctrl: C_RUN});
    tbl.push_back('{in: mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1),    ctrl: C_REDIR});
    tbl.push_back('{in: JALNOOP,                                   ctrl: C_RUN});
    tbl.push_back('{in: mk(3, 1, 0, 0, 3, 1, 2, 0, 3, 0, 0, 1),    ctrl: C_REDIR});
    tbl.push_back('{in: mk(0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1),    ctrl: C_LU});
    tbl.push_back('{in: MR,                                        ctrl: C_RUN});
    tbl.push_back('{in: mk(0, 0, 6, 1, 5, 1, 2, 0, 0, 0, 0, 1),    ctrl: C_RUN});

    // Reset state while reset is held low.
    reset = 1'b0;
    applyStimulus(LU);
    #3;
    checkCtrl("reset_ctrl", C_FREEZE);
    checkOutput("reset_model");
    checkValue("reset_stall", int'(bus.stallCount), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Table of single-cycle vectors from RUN.
    for (int i = 0; i < tbl.size(); i++) step(tbl[i].in, tbl[i].ctrl, $sformatf("table%0d", i));
    checkValue("table_stall", int'(bus.stallCount), 3);
    checkValue("table_flush", int'(bus.flushCount), 3);

    // Load-use costs exactly one stall cycle.
    doReset();
    step(LU, C_LU, "lu_stall_cycle");
    step(LU_BUB, C_RUN, "lu_bubble_cycle");
    checkValue("lu_stallcount", int'(bus.stallCount), 1);
    step(LU_NOUSE, C_RUN, "lu_unused_src");
    checkValue("lu_stallcount_after", int'(bus.stallCount), 1);

    // Branches and gated redirects.
    doReset();
    step(BRT, C_REDIR, "br_taken");
    step(IDLE, C_RUN, "br_after");
    checkValue("br_flushcount", int'(bus.flushCount), 1);
    step(BRNT, C_RUN, "br_not_taken");
    step(JALNOOP, C_RUN, "jal_noop");
    checkValue("br_flushcount_after", int'(bus.flushCount), 1);
    checkValue("br_stallcount", int'(bus.stallCount), 0);

    // Memory wait of 3 cycles, then a same-cycle access.
    doReset();
    for (int i = 0; i < 3; i++) step(MW, C_FREEZE, $sformatf("mw_freeze%0d", i));
    step(MR, C_RUN, "mw_release");
    step(IDLE, C_RUN, "mw_idle");
    checkValue("mw_stallcount", int'(bus.stallCount), 3);
    step(MR, C_RUN, "mw_same_cycle");
    checkValue("mw_stallcount_same", int'(bus.stallCount), 3);

    // Freeze beats redirect; redirect served on the release cycle.
    doReset();
    step(MWB, C_FREEZE, "prio_freeze0");
    step(MWB, C_FREEZE, "prio_freeze1");
    step(MRB, C_REDIR, "prio_release");
    step(IDLE, C_RUN, "prio_idle");
    checkValue("prio_flushcount", int'(bus.flushCount), 1);
    checkValue("prio_stallcount", int'(bus.stallCount), 2);

    // Timeout: 15 frozen cycles, forced release, sticky error.
    doReset();
    for (int i = 0; i < TOUT; i++) step(MW, C_FREEZE, $sformatf("to_freeze%0d", i));
    step(MW, C_RUN, "to_release");
    checkValue("to_memerror", int'(bus.memError), 1);
    for (int i = 0; i < 3; i++) step(IDLE, C_RUN, $sformatf("to_idle%0d", i));
    checkValue("to_memerror_held", int'(bus.memError), 1);
    checkValue("to_stallcount", int'(bus.stallCount), 15);

    // Reset asserted in the middle of a memory wait.
    for (int i = 0; i < 4; i++) step(MW, C_FREEZE, $sformatf("rw_freeze%0d", i));
    applyStimulus(MW);
    #2;
    reset = 1'b0;
    #1;
    checkCtrl("rw_reset_ctrl", C_FREEZE);
    checkValue("rw_reset_stall", int'(bus.stallCount), 0);
    checkValue("rw_reset_err", int'(bus.memError), 0);
    checkOutput("rw_reset_model");
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(IDLE_NRDY, C_RUN, "rw_run_after_reset");

    // Stall counter saturation.
    doReset();
    for (int i = 0; i < 20; i++) step(LU, C_LU, $sformatf("sat_lu%0d", i));
    checkValue("sat_stallcount", int'(bus.stallCount), CNTMAX);
    step(IDLE, C_RUN, "sat_idle");
    checkValue("sat_stallcount_held", int'(bus.stallCount), CNTMAX);

    // Randomized stimulus against the model.
    doReset();
    for (int i = 0; i < 1500; i++) begin
      rv = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 1 : 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 2) != 0) ? 1 : 0);
      if ((i % 250) < 18) begin
        rv.req = 1'b1;
        rv.rdy = 1'b0;
      end
      if ((i % 400) == 399) begin
        applyStimulus(rv);
        reset = 1'b0;
        #2;
        checkOutput($sformatf("rand_reset%0d", i));
        @(posedge clk);
        #1;
        reset = 1'b1;
      end else begin
        applyStimulus(rv);
        #3;
        checkOutput($sformatf("rand%0d", i));
        @(posedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
